golden_nonce_arbiter: RTL

- Collects golden-nonce strobes from NUM_CORES scrypt hashing cores and serialises them onto the single shared serial transmitter.
- The transmitter takes a 32-bit word with a send/busy handshake; busy rises one cycle after send.
- Sits between the core array and serial_transmit inside the top-level miner.
- Provides round-robin fairness, one-deep per-core holding, stale-work flush on new getwork, and sticky overflow reporting.

---
 rtl/golden_nonce_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/golden_nonce_arbiter.sv
// golden_nonce_arbiter
// Gathers golden-nonce strobes from the hashing cores into one-deep per-core
// holding registers and hands them, round-robin, one at a time to the shared
// serial transmitter over a send/busy handshake.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | transmitter free; grant the next pending core if any
// S_WAIT_BUSY | word offered, waiting for tx_busy (abandoned on timeout)
// S_WAIT_IDLE | transmitter busy with our word, waiting for it to finish

module golden_nonce_arbiter #(
   parameter int NUM_CORES    = 4,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NUM_CORES-1:0]     core_golden_i,
   input  logic [32*NUM_CORES-1:0]  core_nonce_i,
   input  logic                     new_work_i,
   input  logic                     clear_overflow_i,
   input  logic                     tx_busy_i,
   output logic                     tx_send_o,
   output logic [31:0]              tx_word_o,
   output logic [NUM_CORES-1:0]     pending_o,
   output logic [NUM_CORES-1:0]     overflow_o,
   output logic [15:0]              sent_count_o
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [7:0] TIMER_LAST = 8'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_IDLE = 2'd2
   } state_t;

   state_t               state_q;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [7:0]           timer_q;
   logic                 tx_send_q;
   logic [31:0]          tx_word_q;
   logic [15:0]          sent_count_q;

   logic [NUM_CORES-1:0] pending_q, pending_d;
   logic [NUM_CORES-1:0] overflow_q, overflow_d;
   logic [31:0]          hold_q [NUM_CORES];
   logic [31:0]          hold_d [NUM_CORES];

   logic                 hi_found, lo_found, grant_found, grant_fire;
   logic [PTR_W-1:0]     hi_idx, lo_idx, grant_idx, rr_next;

   // Round-robin search: lowest pending index at or above rr_ptr, else the
   // lowest pending index overall (which then necessarily lies below rr_ptr).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lo_found = 1'b1;
            lo_idx   = PTR_W'(i);
            if (PTR_W'(i) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = PTR_W'(i);
            end
         end
      end
      grant_found = hi_found | lo_found;
      grant_idx   = hi_found ? hi_idx : lo_idx;
      rr_next     = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
      grant_fire  = (state_q == S_IDLE) && grant_found && !new_work_i;
   end

   // Holding registers: a grant frees its slot in time for a same-edge strobe;
   // new_work flushes everything, including a strobe arriving with it.
   always_comb begin
      pending_d  = pending_q;
      overflow_d = overflow_q & ~{NUM_CORES{clear_overflow_i}};
      hold_d     = hold_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (new_work_i) begin
            pending_d[i] = 1'b0;
         end else begin
            if (grant_fire && (grant_idx == PTR_W'(i))) begin
               pending_d[i] = 1'b0;
            end
            if (core_golden_i[i]) begin
               if (!pending_d[i]) begin
                  hold_d[i]    = core_nonce_i[32*i +: 32];
                  pending_d[i] = 1'b1;
               end else begin
                  overflow_d[i] = 1'b1;
               end
            end
         end
      end
   end

   // Register the per-core holding state.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pending_q  <= '0;
         overflow_q <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         hold_q     <= hold_d;
      end
   end

   // Transmit handshake FSM with registered tx outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         timer_q      <= '0;
         tx_send_q    <= 1'b0;
         tx_word_q    <= '0;
         sent_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_send_q <= 1'b0;
               if (grant_fire) begin
                  tx_word_q    <= hold_q[grant_idx];
                  tx_send_q    <= 1'b1;
                  sent_count_q <= sent_count_q + 16'd1;
                  timer_q      <= '0;
                  rr_ptr_q     <= rr_next;
                  state_q      <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               tx_send_q <= 1'b0;
               if (tx_busy_i) begin
                  state_q <= S_WAIT_IDLE;
               end else if (timer_q == TIMER_LAST) begin
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            S_WAIT_IDLE: begin
               tx_send_q <= 1'b0;
               if (!tx_busy_i) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               tx_send_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_send_o    = tx_send_q;
   assign tx_word_o    = tx_word_q;
   assign pending_o    = pending_q;
   assign overflow_o   = overflow_q;
   assign sent_count_o = sent_count_q;

endmodule
